// File: rtl/spi_cfg_sequencer_pkg.sv
//------------------------------------------------------------------------------
// Module   : spi_cfg_pkg
// Brief    : Shared types and constants for the SPI configuration sequencer.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

package spi_cfg_pkg;

    localparam int c_DEF_WIDTH       = 32;
    localparam int c_DEF_GRST_CYCLES = 4;
    localparam int c_MAX_REQ         = 8;

    typedef enum logic [2:0] {
        ST_INIT   = 3'd0,
        ST_IDLE   = 3'd1,
        ST_SHIFT  = 3'd2,
        ST_LATCH  = 3'd3,
        ST_FINISH = 3'd4
    } state_t;

    function automatic logic [c_MAX_REQ-1:0] onehot(input logic [2:0] idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/spi_cfg_sequencer_rr_arbiter.sv
//------------------------------------------------------------------------------
// Module   : rr_arbiter
// Brief    : Combinational round-robin pick; search starts just after i_ptr.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module rr_arbiter #(
    parameter int N_REQ = 2,
    parameter int IDXW  = 1
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDXW-1:0]  i_ptr,
    output logic [N_REQ-1:0] o_gnt,
    output logic [IDXW-1:0]  o_win
);

    logic [IDXW:0] w_cand;
    logic          w_found;

    always_comb begin
        o_gnt   = '0;
        o_win   = '0;
        w_found = 1'b0;
        w_cand  = '0;
        for (int off = 1; off <= N_REQ; off++) begin
            w_cand = {1'b0, i_ptr} + (IDXW+1)'(off);
            if (w_cand >= (IDXW+1)'(N_REQ)) begin
                w_cand = w_cand - (IDXW+1)'(N_REQ);
            end
            if (!w_found && i_req[w_cand[IDXW-1:0]]) begin
                w_found                    = 1'b1;
                o_gnt[w_cand[IDXW-1:0]]    = 1'b1;
                o_win                      = w_cand[IDXW-1:0];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/spi_cfg_sequencer.sv
//------------------------------------------------------------------------------
// Module   : spi_cfg_sequencer
// Brief    : Arbitrates N_REQ requesters onto one serial config link (SIN/SCK/LOAD).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module spi_cfg_sequencer
    import spi_cfg_pkg::*;
#(
    parameter int N_REQ       = 2,
    parameter int WIDTH       = c_DEF_WIDTH,
    parameter int GRST_CYCLES = c_DEF_GRST_CYCLES
) (
    input  logic                   SCLK,
    input  logic                   RST,
    input  logic [N_REQ-1:0]       REQ,
    input  logic [N_REQ*WIDTH-1:0] DATA,
    input  logic [N_REQ-1:0]       RSEL,
    output logic [N_REQ-1:0]       GNT,
    output logic [N_REQ-1:0]       DONE,
    output logic                   BUSY,
    output logic                   GRST,
    output logic                   SIN,
    output logic                   SCK,
    output logic                   REGSEL,
    output logic                   LOAD
);

    localparam int c_IDXW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int c_BITW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int c_GCW  = $clog2(GRST_CYCLES + 1);

    state_t             r_state;
    logic               r_grst;
    logic               r_busy;
    logic               r_sck;
    logic               r_phase;
    logic               r_regsel;
    logic               r_load;
    logic [N_REQ-1:0]   r_gnt;
    logic [N_REQ-1:0]   r_done;
    logic [c_IDXW-1:0]  r_last;
    logic [c_IDXW-1:0]  r_win;
    logic [WIDTH-1:0]   r_shift;
    logic [c_BITW-1:0]  r_bit;
    logic [c_GCW-1:0]   r_gcnt;

    logic [N_REQ-1:0]   w_arb_gnt;
    logic [c_IDXW-1:0]  w_win;
    logic               w_any;
    logic [WIDTH-1:0]   w_word;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDXW  (c_IDXW)
    ) u_arb (
        .i_req (REQ),
        .i_ptr (r_last),
        .o_gnt (w_arb_gnt),
        .o_win (w_win)
    );

    assign w_any = |w_arb_gnt;

    always_comb begin
        w_word = DATA[WIDTH-1:0];
        for (int i = 1; i < N_REQ; i++) begin
            if (w_win == c_IDXW'(i)) begin
                w_word = DATA[i*WIDTH +: WIDTH];
            end
        end
    end

    // r_last holds the most recent completed winner; reset value makes requester 0 first.
    always_ff @(posedge SCLK) begin
        if (RST) begin
            r_state  <= ST_INIT;
            r_grst   <= 1'b1;
            r_busy   <= 1'b1;
            r_sck    <= 1'b0;
            r_phase  <= 1'b0;
            r_regsel <= 1'b0;
            r_load   <= 1'b0;
            r_gnt    <= '0;
            r_done   <= '0;
            r_last   <= c_IDXW'(N_REQ - 1);
            r_win    <= '0;
            r_shift  <= '0;
            r_bit    <= '0;
            r_gcnt   <= '0;
        end else begin
            r_done <= '0;
            r_load <= 1'b0;
            case (r_state)
                ST_INIT: begin
                    if (r_gcnt == c_GCW'(GRST_CYCLES)) begin
                        r_grst  <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_gcnt <= r_gcnt + 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (w_any) begin
                        r_win    <= w_win;
                        r_gnt    <= N_REQ'(onehot(3'(w_win)));
                        r_regsel <= RSEL[w_win];
                        r_shift  <= w_word;
                        r_sck    <= 1'b0;
                        r_phase  <= 1'b0;
                        r_bit    <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (!r_phase) begin
                        r_sck   <= 1'b1;
                        r_phase <= 1'b1;
                    end else begin
                        r_sck   <= 1'b0;
                        r_phase <= 1'b0;
                        // The LSB stays on SIN through LATCH, so no shift after the last bit.
                        if (r_bit == c_BITW'(WIDTH - 1)) begin
                            r_load  <= 1'b1;
                            r_state <= ST_LATCH;
                        end else begin
                            r_shift <= {r_shift[WIDTH-2:0], 1'b0};
                            r_bit   <= r_bit + 1'b1;
                        end
                    end
                end
                ST_LATCH: begin
                    r_done  <= r_gnt;
                    r_gnt   <= '0;
                    r_last  <= r_win;
                    r_state <= ST_FINISH;
                end
                ST_FINISH: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_INIT;
                end
            endcase
        end
    end

    assign GNT    = r_gnt;
    assign DONE   = r_done;
    assign BUSY   = r_busy;
    assign GRST   = r_grst;
    assign SIN    = r_shift[WIDTH-1];
    assign SCK    = r_sck;
    assign REGSEL = r_regsel;
    assign LOAD   = r_load;

endmodule

`default_nettype wire

// File: tb/tb_spi_cfg_sequencer.sv
//------------------------------------------------------------------------------
// Module   : tb_spi_cfg_sequencer
// Brief    : Scoreboard bench for spi_cfg_sequencer (directed transfers).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_spi_cfg_sequencer;

    localparam int N_REQ       = 2;
    localparam int WIDTH       = 32;
    localparam int GRST_CYCLES = 4;

    logic                   SCLK = 1'b0;
    logic                   RST  = 1'b1;
    logic [N_REQ-1:0]       REQ  = '0;
    logic [N_REQ*WIDTH-1:0] DATA = '0;
    logic [N_REQ-1:0]       RSEL = '0;
    logic [N_REQ-1:0]       GNT;
    logic [N_REQ-1:0]       DONE;
    logic                   BUSY;
    logic                   GRST;
    logic                   SIN;
    logic                   SCK;
    logic                   REGSEL;
    logic                   LOAD;

    always #5 SCLK = ~SCLK;

    spi_cfg_sequencer #(
        .N_REQ       (N_REQ),
        .WIDTH       (WIDTH),
        .GRST_CYCLES (GRST_CYCLES)
    ) dut (
        .SCLK   (SCLK),
        .RST    (RST),
        .REQ    (REQ),
        .DATA   (DATA),
        .RSEL   (RSEL),
        .GNT    (GNT),
        .DONE   (DONE),
        .BUSY   (BUSY),
        .GRST   (GRST),
        .SIN    (SIN),
        .SCK    (SCK),
        .REGSEL (REGSEL),
        .LOAD   (LOAD)
    );

    typedef struct {
        int          idx;
        logic [31:0] word;
        logic        rsel;
    } xfer_t;

    xfer_t sb[$];
    int    tests = 0;
    int    fails = 0;
    int    cyc   = 0;

    always @(posedge SCLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string name);
        tests++;
        fails++;
        $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
    endtask

    // ---------------- monitor ----------------
    int          gnt_start = 0;
    int          load_cyc  = -10;
    int          last_done = -100;
    int          last_gap  = 0;
    int          busy_cnt  = 0;
    int          nbits     = 0;
    logic [31:0] cap       = '0;
    logic        cap_rsel  = 1'b0;
    logic        prev_sck  = 1'b0;
    logic        prev_sin  = 1'b0;
    logic [1:0]  prev_gnt  = '0;
    logic        sin_bad   = 1'b0;
    logic        rsel_bad  = 1'b0;
    logic        multi_gnt = 1'b0;

    always @(negedge SCLK) begin : mon
        xfer_t x;
        if (GNT != 0 && prev_gnt == 0) begin
            last_gap  = cyc - last_done;
            gnt_start = cyc;
            cap       = '0;
            nbits     = 0;
            busy_cnt  = 0;
            cap_rsel  = REGSEL;
            sin_bad   = 1'b0;
            rsel_bad  = 1'b0;
            multi_gnt = 1'b0;
            load_cyc  = -10;
        end
        if (BUSY) busy_cnt++;
        if (GNT != 0 && REGSEL !== cap_rsel) rsel_bad = 1'b1;
        if ($countones(GNT) > 1) multi_gnt = 1'b1;
        if (SCK && prev_sck && SIN !== prev_sin) sin_bad = 1'b1;
        if (SCK && !prev_sck) begin
            cap = {cap[30:0], SIN};
            nbits++;
        end
        if (LOAD) load_cyc = cyc;
        if (DONE != 0) begin
            last_done = cyc;
            if (sb.size() == 0) begin
                check("unexpected_done", 64'(DONE), 64'd0);
            end else begin
                x = sb.pop_front();
                check("done_target", 64'(DONE), 64'(1 << x.idx));
                check("shifted_word", 64'(cap), 64'(x.word));
                check("regsel", 64'(cap_rsel), 64'(x.rsel));
                check("sck_rises", 64'(nbits), 64'd32);
                check("done_latency", 64'(cyc - gnt_start), 64'd65);
                check("load_before_done", 64'(cyc - load_cyc), 64'd1);
                check("busy_cycles", 64'(busy_cnt), 64'd66);
                check("gnt_clear_at_done", 64'(GNT), 64'd0);
                check("link_integrity", 64'({sin_bad, rsel_bad, multi_gnt}), 64'd0);
            end
        end
        prev_sck = SCK;
        prev_sin = SIN;
        prev_gnt = GNT;
    end

    // ---------------- stimulus helpers ----------------
    task automatic push(input int idx, input logic [31:0] word, input logic rsel);
        xfer_t x;
        x.idx  = idx;
        x.word = word;
        x.rsel = rsel;
        sb.push_back(x);
    endtask

    task automatic wait_gnt(input string name);
        int n = 0;
        @(negedge SCLK);
        while (GNT == 0 && n < 100) begin
            @(negedge SCLK);
            n++;
        end
        if (GNT == 0) timeout(name);
    endtask

    task automatic wait_empty(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 400) begin
            @(negedge SCLK);
            #1;
            n++;
        end
        if (sb.size() != 0) timeout(name);
    endtask

    task automatic wait_grst_low(input string name);
        int n = 0;
        while (GRST !== 1'b0 && n < 50) begin
            @(negedge SCLK);
            n++;
        end
        if (GRST !== 1'b0) timeout(name);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run, %0d failed", tests, fails);
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin : stim
        logic seen_gnt;
        // Reset release and GRST sequence
        @(posedge SCLK);
        @(negedge SCLK);
        check("rst_grst", 64'(GRST), 64'd1);
        check("rst_busy", 64'(BUSY), 64'd1);
        check("rst_outputs", 64'({SIN, SCK, REGSEL, LOAD, GNT, DONE}), 64'd0);
        repeat (2) @(posedge SCLK);
        #1 RST = 1'b0;
        for (int i = 1; i <= GRST_CYCLES; i++) begin
            @(posedge SCLK);
            @(negedge SCLK);
            check($sformatf("grst_hold_%0d", i), 64'({GRST, BUSY}), 64'b11);
            check("init_outputs", 64'({SIN, SCK, REGSEL, LOAD, GNT, DONE}), 64'd0);
        end
        @(posedge SCLK);
        @(negedge SCLK);
        check("grst_release", 64'({GRST, BUSY}), 64'b00);
        check("idle_outputs", 64'({SIN, SCK, REGSEL, LOAD, GNT, DONE}), 64'd0);

        // Single transfer from requester 0
        #1;
        DATA[31:0] = 32'hA5C3_0F81;
        RSEL[0]    = 1'b1;
        REQ        = 2'b01;
        push(0, 32'hA5C3_0F81, 1'b1);
        wait_gnt("single_gnt");
        check("single_gnt_onehot", 64'(GNT), 64'b01);
        check("single_regsel_live", 64'(REGSEL), 64'd1);
        wait_empty("single_done");
        REQ = 2'b00;

        // Data/RSEL changed one cycle after grant must not disturb the transfer
        repeat (2) @(posedge SCLK);
        #1;
        DATA[31:0] = 32'h3C96_E71B;
        RSEL[0]    = 1'b1;
        REQ        = 2'b01;
        push(0, 32'h3C96_E71B, 1'b1);
        wait_gnt("stable_gnt");
        @(posedge SCLK);
        #1;
        DATA[31:0] = 32'h0;
        RSEL[0]    = 1'b0;
        wait_empty("stable_done");
        REQ = 2'b00;

        // Abort at bit 10: last completed winner was 0, but reset makes 0 first again
        repeat (2) @(posedge SCLK);
        #1;
        DATA[31:0] = 32'hFFFF_0000;
        RSEL[0]    = 1'b1;
        REQ        = 2'b01;
        wait_gnt("abort_gnt");
        repeat (21) @(posedge SCLK);
        @(negedge SCLK);
        check("abort_bit10_sck_high", 64'(SCK), 64'd1);
        #1;
        RST        = 1'b1;
        REQ        = 2'b11;
        DATA[31:0] = 32'h8000_0001;
        RSEL[0]    = 1'b0;
        DATA[63:32] = 32'h7E3C_19D2;
        RSEL[1]    = 1'b1;
        @(posedge SCLK);
        @(negedge SCLK);
        check("abort_sck_gnt", 64'({SCK, GNT}), 64'd0);
        check("abort_load_done", 64'({LOAD, DONE}), 64'd0);
        check("abort_grst_busy", 64'({GRST, BUSY}), 64'b11);
        @(posedge SCLK);
        #1 RST = 1'b0;
        // Contention right after recovery: 0,1,0,1 with REQ held
        push(0, 32'h8000_0001, 1'b0);
        push(1, 32'h7E3C_19D2, 1'b1);
        push(0, 32'h8000_0001, 1'b0);
        push(1, 32'h7E3C_19D2, 1'b1);
        wait_grst_low("abort_grst_reissue");
        wait_empty("contention_done");
        REQ = 2'b00;
        check("contention_idle_gap", 64'(last_gap), 64'd2);

        // Requester 1 drops REQ mid-transfer; DONE still pulses, no re-grant
        repeat (2) @(posedge SCLK);
        #1;
        DATA[63:32] = 32'hDEAD_BEEF;
        RSEL[1]     = 1'b0;
        REQ         = 2'b10;
        push(1, 32'hDEAD_BEEF, 1'b0);
        wait_gnt("drop_gnt");
        check("drop_gnt_onehot", 64'(GNT), 64'b10);
        repeat (20) @(posedge SCLK);
        #1 REQ = 2'b00;
        wait_empty("drop_done");
        seen_gnt = 1'b0;
        repeat (10) begin
            @(negedge SCLK);
            if (GNT != 0) seen_gnt = 1'b1;
        end
        check("drop_no_regrant", 64'(seen_gnt), 64'd0);
        check("drop_idle_busy", 64'(BUSY), 64'd0);
        check("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/spi_cfg_sequencer.md
Name: spi_cfg_sequencer

Overview:
- Shares the single serial configuration link to the 32-bit serial-to-parallel interface chip between N_REQ on-FPGA requesters.
- After reset, issues the chip global reset (GRST).
- Round-robin arbitrates the requesters.
- Shifts the winner's word MSB-first on SIN against a generated shift clock SCK, then pulses LOAD so the chip transfers the word to its parallel outputs.
- Sits between the configuration masters and the chip's SIN/SCLK/REGSEL/RESET pins; the chip's active-low RESET is driven from ~GRST at the top level.

Parameters:
- N_REQ, 2: number of requesters (2..8).
- WIDTH, 32: bits per configuration word.
- GRST_CYCLES, 4: SCLK cycles GRST is held high after RST deasserts (>=1).

Ports:
- SCLK  in  1: system clock; all logic on rising edge.
- RST  in  1: synchronous, active-high reset.
- REQ  in  N_REQ: per-requester transfer request; held high until that requester's DONE.
- DATA  in  N_REQ*WIDTH: requester i word at [i*WIDTH +: WIDTH]; sampled only at grant.
- RSEL  in  N_REQ: requester i target register select; sampled at grant.
- GNT  out  N_REQ: one-hot grant, high for the whole transfer.
- DONE  out  N_REQ: one-cycle completion pulse to the granted requester.
- BUSY  out  1: high in every state except IDLE.
- GRST  out  1: chip global reset, active-high.
- SIN  out  1: serial data to chip.
- SCK  out  1: shift clock to chip; chip samples SIN on the SCK rising edge.
- REGSEL  out  1: register select to chip, stable for the whole transfer.
- LOAD  out  1: one-cycle parallel-load strobe.

Behaviour:
- Reset (RST=1 at an edge, any state, including mid-transfer):
  - state INIT, GRST=1, BUSY=1.
  - SIN=0, SCK=0, REGSEL=0, LOAD=0, GNT=0, DONE=0.
  - Round-robin pointer set so requester 0 has highest priority; bit and phase counters cleared.
  - An interrupted transfer is abandoned, with no DONE.
- INIT:
  - GRST stays 1 for GRST_CYCLES cycles after the first edge with RST=0.
  - Then GRST=0 and the state goes to IDLE (BUSY=0).
- IDLE, at the edge where any REQ=1:
  - Round-robin pick: highest priority is the index after the last granted one, wrapping.
  - Load the shift register from the winner's DATA; REGSEL <= winner's RSEL.
  - GNT <= onehot(winner); SIN <= DATA[WIDTH-1]; SCK=0; state SHIFT, phase 0.
  - If no REQ, all outputs hold their idle values.
- SHIFT: each bit takes 2 cycles.
  - Phase 0: SCK=0, SIN = current bit.
  - Phase 1: SCK=1.
  - On the phase-1 -> phase-0 edge, shift left and present the next bit.
  - SIN changes only while SCK=0.
  - With the request accepted at edge k: SCK rises for bit b (b=0 is the MSB) in cycle k+2+2b; the last rise is in cycle k+2*WIDTH.
- LATCH, entered at edge k+2*WIDTH:
  - SCK=0, LOAD=1 for exactly one cycle; SIN holds the LSB.
- FINISH, next edge:
  - LOAD=0, DONE[winner]=1 for one cycle, GNT=0 in the same cycle.
  - Pointer updated to the winner; then IDLE (BUSY=0 the following cycle).
- Total occupancy: 2*WIDTH+2 cycles from acceptance to DONE.
- Minimum gap between transfers: 1 IDLE cycle.
- REQ changes during a transfer:
  - REQ deasserted mid-transfer is ignored; the transfer completes and DONE still pulses.
  - New REQs are queued by level and are not sampled until IDLE.
- Simultaneous requests in IDLE: exactly one grant, per the round-robin pointer; never two GNT bits high.
- A requester still asserting REQ in the IDLE cycle after its DONE loses to any other pending requester.
- DATA and RSEL changes after grant have no effect.
- REGSEL, GNT and the shifted word are constant from grant through FINISH.

Decomposition:
- Package spi_cfg_pkg:
  - State enum INIT/IDLE/SHIFT/LATCH/FINISH.
  - Default WIDTH=32 and GRST_CYCLES constants.
  - Function onehot(idx) for GNT generation.
- One sub-module, rr_arbiter (N_REQ param):
  - Inputs: REQ vector, pointer.
  - Outputs: one-hot grant and winner index.
  - Purely combinational; the pointer register lives in the top FSM.

Test Plan:
- Reset release: RST high 3 cycles then low, GRST_CYCLES=4 -> GRST=1 through 4 cycles after release, then 0; BUSY falls with GRST; all other outputs 0 throughout.
- Single transfer: REQ[0]=1, DATA0=32'hA5C3_0F81, RSEL0=1 -> GNT=2'b01 next cycle, REGSEL=1, 32 SCK rising edges.
  - SIN bits sampled at SCK rises equal A5C30F81 MSB-first.
  - LOAD pulse at cycle k+65, DONE[0] at k+66, BUSY total 66 cycles.
- Contention: REQ=2'b11 held continuously -> grants alternate 0,1,0,1; each DONE targets the granted index; one IDLE cycle between transfers.
- Data stability: change DATA0 to 0 and RSEL0 to 0 one cycle after grant -> shifted word and REGSEL unchanged.
- Abort: assert RST at bit 10 of a transfer -> SCK=0 and GNT=0 next cycle, no DONE or LOAD, GRST reissued, requester 0 wins first after recovery.
- Requester drop: REQ[1] deasserted mid-transfer -> transfer completes, DONE[1] pulses, no re-grant.
